decoder_scan_ctrl: RTL

Time-multiplexing sequencer that sits directly upstream of the 2-to-4 decoder and drives its `a[1:0]` and `enable` inputs.
- Steps through the four decoder channels, holding each one active for a programmable number of clocks.
- Inserts a blanking gap, with enable low, between channels to avoid ghosting on scanned LED/7-seg displays.
- Skips masked channels and flags slot and frame boundaries for downstream data muxing.

---
 rtl/decoder_scan_ctrl_pkg.sv | 36 +++
 rtl/decoder_scan_ctrl_tick_counter.sv | 29 ++
 rtl/decoder_scan_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
package decoder_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    // Next unmasked channel strictly above cur, wrapping modulo NUM_CH.
    // If cur is the only unmasked channel it is returned; with an empty mask cur is returned.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0]  cur,
                                                 input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] idx;
        logic             found;
        next_ch = cur;
        found   = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // cur is the highest unmasked channel when advancing from it wraps (or stays put).
    function automatic logic is_last_ch(input logic [SEL_W-1:0]  cur,
                                        input logic [NUM_CH-1:0] mask);
        return next_ch(cur, mask) <= cur;
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_tick_counter.sv
// Loadable saturating down-counter timing the ACTIVE and BLANK phases.
module scan_tick_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Time-multiplexing sequencer driving a 2-to-4 decoder's a[1:0] and enable.
// Channels are held active CLK_DIV clocks, separated by BLANK_CYCLES of enable low.
// Build option: define DECODER_SCAN_MASK_EN to honour the mask port; otherwise
// all four channels are scanned in fixed rotation and mask is ignored.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       enable,
    output logic       slot_done,
    output logic       frame_done
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + BLANK_CYCLES + 1);
    localparam logic [CNT_W-1:0] ACT_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic [NUM_CH-1:0] eff_mask;

`ifdef DECODER_SCAN_MASK_EN
    assign eff_mask = mask;
`else
    logic unused_mask;
    assign unused_mask = ^mask;
    assign eff_mask    = '1;
`endif

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              en_q, en_d;
    logic              sd_q, sd_d;
    logic              fd_q, fd_d;
    logic [NUM_CH-1:0] mask_q, mask_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;
    logic              advance;
    logic              from_idle;

    scan_tick_counter #(
        .WIDTH (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Next-state and next-output decode; outputs are computed one clock ahead so they can be registered.
    // mask_q holds the mask latched at slot entry so frame_done ignores mid-slot mask changes.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        en_d         = en_q;
        sd_d         = 1'b0;
        fd_d         = 1'b0;
        mask_d       = mask_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        advance      = 1'b0;
        from_idle    = 1'b0;

        if (!run) begin
            state_d  = IDLE;
            en_d     = 1'b0;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    advance   = 1'b1;
                    from_idle = 1'b1;
                end
                ACTIVE: begin
                    if (cnt_zero) begin
                        if (BLANK_CYCLES > 0) begin
                            state_d      = BLANK;
                            en_d         = 1'b0;
                            cnt_load     = 1'b1;
                            cnt_load_val = BLANK_LOAD;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        sd_d = (cnt == CNT_W'(1));
                        fd_d = sd_d && is_last_ch(sel_q, mask_q);
                    end
                end
                BLANK: begin
                    if (cnt_zero) begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    en_d     = 1'b0;
                    cnt_load = 1'b1;
                end
            endcase

            // Slot advance: the only point where the mask is sampled.
            if (advance) begin
                cnt_load = 1'b1;
                if (eff_mask == '0) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end else begin
                    state_d      = ACTIVE;
                    en_d         = 1'b1;
                    sel_d        = next_ch(from_idle ? SEL_W'(NUM_CH - 1) : sel_q, eff_mask);
                    mask_d       = eff_mask;
                    cnt_load_val = ACT_LOAD;
                    sd_d         = (CLK_DIV == 1);
                    fd_d         = sd_d && is_last_ch(sel_d, eff_mask);
                end
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            sd_q    <= 1'b0;
            fd_q    <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            sd_q    <= sd_d;
            fd_q    <= fd_d;
            mask_q  <= mask_d;
        end
    end

    assign sel        = sel_q;
    assign enable     = en_q;
    assign slot_done  = sd_q;
    assign frame_done = fd_q;

endmodule
